// File: rtl/data_mem_arbiter_pkg.sv
// Shared widths, FSM states and helpers for the
// two-port data-memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int LEN_W  = 3;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } arb_state_t;

  function automatic logic [1:0] port_mask(
    input logic p
  );
    return p ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/data_mem_arbiter_rr_pick2.sv
// Two-way round-robin selector: on contention the
// port that did not own the previous burst wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       winner,
  output logic       valid
);

  always_comb begin
    valid  = |req;
    winner = 1'b0;
    unique case (1'b1)
      (req == 2'b11): winner = ~last_owner;
      (req == 2'b10): winner = 1'b1;
      default:        winner = 1'b0;
    endcase
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbiter and burst sequencer sharing one 256x8
// data memory between the LSU (port 0) and DMA (port 1).
module data_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int MAX_BEATS = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] we,
  input  logic [ADDR_W-1:0]  p0_addr,
  input  logic [ADDR_W-1:0]  p1_addr,
  input  logic [LEN_W-1:0]   p0_len,
  input  logic [LEN_W-1:0]   p1_len,
  input  logic [DATA_W-1:0]  p0_wdata,
  input  logic [DATA_W-1:0]  p1_wdata,
  output logic [NUM_REQ-1:0] gnt,
  output logic [NUM_REQ-1:0] beat,
  output logic [DATA_W-1:0]  rdata,
  output logic [NUM_REQ-1:0] rdata_valid,
  output logic [NUM_REQ-1:0] done,
  output logic               mem_read,
  output logic               mem_write,
  output logic [ADDR_W-1:0]  mem_address,
  output logic [DATA_W-1:0]  mem_data_in,
  input  logic [DATA_W-1:0]  mem_data_out
);

  localparam int CNT_W = $clog2(MAX_BEATS);

  arb_state_t state_q, state_d;

  logic              owner_q, owner_d;
  logic              last_owner_q, last_owner_d;
  logic              cur_we_q, cur_we_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]  cur_len_q, cur_len_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0]  beat_nxt;

  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        beat_q, beat_d;
  logic [1:0]        rvalid_q, rvalid_d;
  logic [1:0]        done_q, done_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              mrd_q, mrd_d;
  logic              mwr_q, mwr_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;

  logic              win;
  logic              win_valid;
  logic [ADDR_W-1:0] win_addr;
  logic [LEN_W-1:0]  win_len;
  logic              win_we;

  rr_pick2 u_pick (
    .req        (req),
    .last_owner (last_owner_q),
    .winner     (win),
    .valid      (win_valid)
  );

  assign win_addr = win ? p1_addr : p0_addr;
  assign win_len  = win ? p1_len : p0_len;
  assign win_we   = we[win];
  assign beat_nxt = beat_cnt_q + CNT_W'(1);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cur_we_d     = cur_we_q;
    cur_addr_d   = cur_addr_q;
    cur_len_d    = cur_len_q;
    beat_cnt_d   = beat_cnt_q;
    gnt_d        = gnt_q;
    beat_d       = beat_q;
    rvalid_d     = 2'b00;
    done_d       = 2'b00;
    rdata_d      = rdata_q;
    mrd_d        = mrd_q;
    mwr_d        = mwr_q;
    maddr_d      = maddr_q;
    unique case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d    = ACCESS;
          owner_d    = win;
          cur_we_d   = win_we;
          cur_addr_d = win_addr;
          cur_len_d  = win_len;
          beat_cnt_d = '0;
          gnt_d      = port_mask(win);
          beat_d     = port_mask(win);
          mrd_d      = ~win_we;
          mwr_d      = win_we;
          maddr_d    = win_addr;
        end
      end
      ACCESS: begin
        if (!cur_we_q) begin
          rdata_d  = mem_data_out;
          rvalid_d = port_mask(owner_q);
        end
        if (beat_cnt_q == cur_len_q) begin
          state_d = DONE;
          beat_d  = 2'b00;
          mrd_d   = 1'b0;
          mwr_d   = 1'b0;
          done_d  = port_mask(owner_q);
        end else begin
          beat_cnt_d = beat_nxt;
          // 8-bit add wraps 0xFF -> 0x00
          maddr_d    = cur_addr_q + ADDR_W'(beat_nxt);
        end
      end
      DONE: begin
        state_d      = IDLE;
        gnt_d        = 2'b00;
        last_owner_d = owner_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      cur_we_q     <= 1'b0;
      cur_addr_q   <= '0;
      cur_len_q    <= '0;
      beat_cnt_q   <= '0;
      gnt_q        <= 2'b00;
      beat_q       <= 2'b00;
      rvalid_q     <= 2'b00;
      done_q       <= 2'b00;
      rdata_q      <= '0;
      mrd_q        <= 1'b0;
      mwr_q        <= 1'b0;
      maddr_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cur_we_q     <= cur_we_d;
      cur_addr_q   <= cur_addr_d;
      cur_len_q    <= cur_len_d;
      beat_cnt_q   <= beat_cnt_d;
      gnt_q        <= gnt_d;
      beat_q       <= beat_d;
      rvalid_q     <= rvalid_d;
      done_q       <= done_d;
      rdata_q      <= rdata_d;
      mrd_q        <= mrd_d;
      mwr_q        <= mwr_d;
      maddr_q      <= maddr_d;
    end
  end

  assign gnt         = gnt_q;
  assign beat        = beat_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rvalid_q;
  assign done        = done_q;
  assign mem_read    = mrd_q;
  assign mem_write   = mwr_q;
  assign mem_address = maddr_q;

  // write data flows straight from the owner
  assign mem_data_in = mwr_q ?
    (owner_q ? p1_wdata : p0_wdata) : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomized bench for data_mem_arbiter with a behavioural
// memory and a burst-level reference model.
module tb_data_mem_arbiter;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [1:0] req, we;
  logic [7:0] p0_addr, p1_addr;
  logic [2:0] p0_len, p1_len;
  logic [7:0] p0_wdata, p1_wdata;
  logic [1:0] gnt, beat, rdata_valid, done;
  logic [7:0] rdata;
  logic       mem_read, mem_write;
  logic [7:0] mem_address, mem_data_in, mem_data_out;

  data_mem_arbiter #(.NUM_REQ(2), .MAX_BEATS(8)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .req          (req),
    .we           (we),
    .p0_addr      (p0_addr),
    .p1_addr      (p1_addr),
    .p0_len       (p0_len),
    .p1_len       (p1_len),
    .p0_wdata     (p0_wdata),
    .p1_wdata     (p1_wdata),
    .gnt          (gnt),
    .beat         (beat),
    .rdata        (rdata),
    .rdata_valid  (rdata_valid),
    .done         (done),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  always #5 clock = ~clock;

  logic [7:0] mem [256];
  logic [7:0] refm [256];
  logic       init_en = 1'b0;
  logic       pl_en = 1'b0;
  logic [7:0] pl_addr, pl_data;

  always @(negedge clock) begin
    if (init_en) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
    end else if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (mem_write) begin
      mem[mem_address] <= mem_data_in;
    end
  end

  assign mem_data_out = mem[mem_address];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;
  int beats[2];
  int dones[2];
  int widx[2];
  int rd_strobes, wr_strobes, onehot_bad;
  logic [7:0] wq0[$], wq1[$], rq0[$], rq1[$];
  int gnt_port[$], gnt_cyc[$], done_cyc[$];
  logic [1:0] prev_gnt;

  task automatic clear_stats();
    cyc = 0;
    beats = '{0, 0};
    dones = '{0, 0};
    widx = '{0, 0};
    rd_strobes = 0;
    wr_strobes = 0;
    onehot_bad = 0;
    wq0.delete(); wq1.delete();
    rq0.delete(); rq1.delete();
    gnt_port.delete(); gnt_cyc.delete();
    done_cyc.delete();
    prev_gnt = gnt;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
    for (int p = 0; p < 2; p++) begin
      if (gnt[p] && !prev_gnt[p]) begin
        gnt_port.push_back(p);
        gnt_cyc.push_back(cyc);
      end
    end
    prev_gnt = gnt;
    if (gnt == 2'b11) onehot_bad++;
    if (mem_read) rd_strobes++;
    if (mem_write) wr_strobes++;
    if (beat[0]) begin
      beats[0]++;
      if (mem_write) begin
        p0_wdata = (widx[0] < wq0.size()) ? wq0[widx[0]] : 8'h00;
        widx[0]++;
      end
    end
    if (beat[1]) begin
      beats[1]++;
      if (mem_write) begin
        p1_wdata = (widx[1] < wq1.size()) ? wq1[widx[1]] : 8'h00;
        widx[1]++;
      end
    end
    if (rdata_valid[0]) rq0.push_back(rdata);
    if (rdata_valid[1]) rq1.push_back(rdata);
    if (done[0]) begin dones[0]++; done_cyc.push_back(cyc); end
    if (done[1]) begin dones[1]++; done_cyc.push_back(cyc); end
  endtask

  task automatic wait_done(input int p, input int n,
                           output bit ok);
    int k = 0;
    while (dones[p] < n && k < 40) begin
      step();
      k++;
    end
    ok = (dones[p] >= n);
  endtask

  function automatic int mem_diffs();
    int n = 0;
    for (int i = 0; i < 256; i++)
      if (mem[i] !== refm[i]) n++;
    return n;
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    req = 2'b00;
    step();
    step();
    reset_n = 1'b1;
    clear_stats();
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en = 1'b1;
    @(negedge clock);
    #1;
    pl_en = 1'b0;
    refm[a] = d;
  endtask

  task automatic test_reset();
    logic [47:0] outs;
    reset_n = 1'b0;
    req = 2'b11;
    step();
    step();
    outs = {gnt, beat, rdata, rdata_valid, done, mem_read,
            mem_write, mem_address, mem_data_in};
    n_cmp++;
    if (outs !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h, want 0", outs);
    end
    req = 2'b00;
    reset_n = 1'b1;
    step();
    n_cmp++;
    if (gnt !== 2'b00 || mem_read !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_after_reset: gnt=%b rd=%b, want 00/0",
               gnt, mem_read);
    end
    clear_stats();
  endtask

  task automatic test_single_read();
    preload(8'h10, 8'hA5);
    clear_stats();
    we[0] = 1'b0;
    p0_addr = 8'h10;
    p0_len = 3'd0;
    req[0] = 1'b1;
    step();
    req[0] = 1'b0;
    n_cmp++;
    if (gnt !== 2'b01 || mem_read !== 1'b1 || mem_address !== 8'h10) begin
      n_bad++;
      $display("FAIL single_read_t1: gnt=%b rd=%b addr=%h, want 01/1/10",
               gnt, mem_read, mem_address);
    end
    step();
    n_cmp++;
    if (done !== 2'b01 || rdata_valid !== 2'b01 || rdata !== 8'hA5) begin
      n_bad++;
      $display("FAIL single_read_done: done=%b rv=%b rdata=%h, want 01/01/a5",
               done, rdata_valid, rdata);
    end
    n_cmp++;
    if (gnt !== 2'b01) begin
      n_bad++;
      $display("FAIL single_read_gnt_in_done: gnt=%b, want 01", gnt);
    end
    step();
    step();
    n_cmp++;
    if (rd_strobes !== 1 || dones[0] !== 1 || gnt !== 2'b00) begin
      n_bad++;
      $display("FAIL single_read_counts: rd=%0d done=%0d gnt=%b, want 1/1/00",
               rd_strobes, dones[0], gnt);
    end
  endtask

  task automatic test_write_wrap();
    bit ok;
    logic [7:0] d [4];
    d = '{8'h11, 8'h22, 8'h33, 8'h44};
    clear_stats();
    for (int i = 0; i < 4; i++) begin
      wq1.push_back(d[i]);
      refm[8'(8'hFE + i)] = d[i];
    end
    we[1] = 1'b1;
    p1_addr = 8'hFE;
    p1_len = 3'd3;
    req[1] = 1'b1;
    step();
    req[1] = 1'b0;
    wait_done(1, 1, ok);
    step();
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL write_wrap_timeout: done=%0d, want 1", dones[1]);
    end
    n_cmp++;
    if (beats[1] !== 4 || wr_strobes !== 4 || beats[0] !== 0) begin
      n_bad++;
      $display("FAIL write_wrap_beats: beat1=%0d wr=%0d beat0=%0d, want 4/4/0",
               beats[1], wr_strobes, beats[0]);
    end
    n_cmp++;
    if (mem[8'hFE] !== 8'h11 || mem[8'hFF] !== 8'h22 ||
        mem[8'h00] !== 8'h33 || mem[8'h01] !== 8'h44) begin
      n_bad++;
      $display("FAIL write_wrap_data: %h %h %h %h, want 11 22 33 44",
               mem[8'hFE], mem[8'hFF], mem[8'h00], mem[8'h01]);
    end
    n_cmp++;
    if (mem_diffs() != 0) begin
      n_bad++;
      $display("FAIL write_wrap_mem: %0d bytes differ, want 0", mem_diffs());
    end
  endtask

  task automatic test_contention();
    do_reset();
    for (int round = 0; round < 2; round++) begin
      int l0, l1, k, exp_p, exp_d, lp;
      l0 = (round == 0) ? 1 : $urandom_range(0, 7);
      l1 = (round == 0) ? 1 : $urandom_range(0, 7);
      clear_stats();
      p0_addr = 8'($urandom);
      p1_addr = 8'($urandom);
      p0_len = 3'(l0);
      p1_len = 3'(l1);
      we = 2'b00;
      req = 2'b11;
      k = 0;
      while (gnt_port.size() < 4 && k < 200) begin
        step();
        k++;
      end
      req = 2'b00;
      k = 0;
      while ((dones[0] + dones[1]) < gnt_port.size() && k < 40) begin
        step();
        k++;
      end
      step();
      n_cmp++;
      if (gnt_port.size() < 4 || dones[0] + dones[1] != 4) begin
        n_bad++;
        $display("FAIL contention_timeout: grants=%0d dones=%0d, want 4/4",
                 gnt_port.size(), dones[0] + dones[1]);
      end else begin
        for (int i = 0; i < 4; i++) begin
          exp_p = (round == 0) ? (i % 2) : (gnt_port[0] ^ (i % 2));
          n_cmp++;
          if (gnt_port[i] != exp_p) begin
            n_bad++;
            $display("FAIL contention_order[%0d]: port %0d, want %0d",
                     i, gnt_port[i], exp_p);
          end
        end
        for (int i = 0; i < 3; i++) begin
          exp_d = ((gnt_port[i] == 1) ? l1 : l0) + 3;
          n_cmp++;
          if (gnt_cyc[i+1] - gnt_cyc[i] != exp_d) begin
            n_bad++;
            $display("FAIL contention_spacing[%0d]: %0d cycles, want %0d",
                     i, gnt_cyc[i+1] - gnt_cyc[i], exp_d);
          end
        end
      end
      n_cmp++;
      if (rq0.size() != dones[0] * (l0 + 1) ||
          rq1.size() != dones[1] * (l1 + 1) || onehot_bad != 0) begin
        n_bad++;
        $display("FAIL contention_reads: n0=%0d n1=%0d oh=%0d, want %0d/%0d/0",
                 rq0.size(), rq1.size(), onehot_bad,
                 dones[0] * (l0 + 1), dones[1] * (l1 + 1));
      end
      for (int j = 0; j < rq0.size(); j++) begin
        lp = j % (l0 + 1);
        n_cmp++;
        if (rq0[j] !== refm[8'(p0_addr + lp)]) begin
          n_bad++;
          $display("FAIL contention_rdata0[%0d]: %h, want %h",
                   j, rq0[j], refm[8'(p0_addr + lp)]);
        end
      end
      for (int j = 0; j < rq1.size(); j++) begin
        lp = j % (l1 + 1);
        n_cmp++;
        if (rq1[j] !== refm[8'(p1_addr + lp)]) begin
          n_bad++;
          $display("FAIL contention_rdata1[%0d]: %h, want %h",
                   j, rq1[j], refm[8'(p1_addr + lp)]);
        end
      end
    end
  endtask

  task automatic test_drop_mid_burst();
    int k;
    bit ok;
    clear_stats();
    p0_addr = 8'($urandom);
    p0_len = 3'd7;
    we[0] = 1'b0;
    req[0] = 1'b1;
    k = 0;
    while (beats[0] < 3 && k < 20) begin
      step();
      k++;
    end
    req[0] = 1'b0;
    wait_done(0, 1, ok);
    for (int i = 0; i < 6; i++) step();
    n_cmp++;
    if (!ok || beats[0] != 8 || dones[0] != 1 || gnt_port.size() != 1) begin
      n_bad++;
      $display("FAIL drop_burst: beats=%0d done=%0d grants=%0d, want 8/1/1",
               beats[0], dones[0], gnt_port.size());
    end
    n_cmp++;
    if (rq0.size() != 8) begin
      n_bad++;
      $display("FAIL drop_rcount: %0d reads, want 8", rq0.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_cmp++;
        if (rq0[i] !== refm[8'(p0_addr + i)]) begin
          n_bad++;
          $display("FAIL drop_rdata[%0d]: %h, want %h",
                   i, rq0[i], refm[8'(p0_addr + i)]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    int k;
    logic [47:0] outs;
    clear_stats();
    p0_addr = 8'($urandom);
    p0_len = 3'd7;
    we[0] = 1'b1;
    for (int i = 0; i < 8; i++) wq0.push_back(8'($urandom));
    for (int i = 0; i < 3; i++) refm[8'(p0_addr + i)] = wq0[i];
    req[0] = 1'b1;
    k = 0;
    while (beats[0] < 3 && k < 20) begin
      step();
      k++;
    end
    reset_n = 1'b0;
    req = 2'b00;
    step();
    outs = {gnt, beat, rdata, rdata_valid, done, mem_read,
            mem_write, mem_address, mem_data_in};
    n_cmp++;
    if (mem_write !== 1'b0 || outs !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_outputs: wr=%b outs=%h, want 0/0",
               mem_write, outs);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) step();
    n_cmp++;
    if (dones[0] != 0 || beats[0] != 3 || wr_strobes != 3) begin
      n_bad++;
      $display("FAIL reset_mid_abort: done=%0d beats=%0d wr=%0d, want 0/3/3",
               dones[0], beats[0], wr_strobes);
    end
    n_cmp++;
    if (mem_diffs() != 0) begin
      n_bad++;
      $display("FAIL reset_mid_mem: %0d bytes differ, want 0", mem_diffs());
    end
  endtask

  task automatic test_back_to_back();
    int l, k;
    l = $urandom_range(0, 7);
    clear_stats();
    p1_addr = 8'($urandom);
    p1_len = 3'(l);
    we[1] = 1'b1;
    for (int i = 0; i < 4 * (l + 1); i++) wq1.push_back(8'($urandom));
    for (int b = 0; b < 4; b++)
      for (int i = 0; i <= l; i++)
        refm[8'(p1_addr + i)] = wq1[b * (l + 1) + i];
    req[1] = 1'b1;
    k = 0;
    while (gnt_port.size() < 4 && k < 100) begin
      step();
      k++;
    end
    req[1] = 1'b0;
    k = 0;
    while (dones[1] < gnt_port.size() && k < 40) begin
      step();
      k++;
    end
    step();
    n_cmp++;
    if (gnt_port.size() != 4 || dones[1] != 4 || beats[0] != 0) begin
      n_bad++;
      $display("FAIL b2b_count: grants=%0d dones=%0d beat0=%0d, want 4/4/0",
               gnt_port.size(), dones[1], beats[0]);
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (gnt_port[i+1] != 1 || gnt_cyc[i+1] - done_cyc[i] != 2) begin
          n_bad++;
          $display("FAIL b2b_gap[%0d]: port=%0d gap=%0d, want 1/2",
                   i, gnt_port[i+1], gnt_cyc[i+1] - done_cyc[i]);
        end
      end
    end
    n_cmp++;
    if (mem_diffs() != 0) begin
      n_bad++;
      $display("FAIL b2b_mem: %0d bytes differ, want 0", mem_diffs());
    end
  endtask

  task automatic test_random_bursts();
    int p, l, tot;
    bit w, ok;
    logic [7:0] a;
    tot = 0;
    for (int it = 0; it < 24; it++) begin
      p = $urandom_range(0, 1);
      w = 1'($urandom);
      l = $urandom_range(0, 7);
      a = 8'($urandom);
      clear_stats();
      for (int i = 0; i <= l; i++) begin
        if (p == 0) wq0.push_back(8'($urandom));
        else wq1.push_back(8'($urandom));
      end
      if (p == 0) begin p0_addr = a; p0_len = 3'(l); end
      else begin p1_addr = a; p1_len = 3'(l); end
      we[p] = w;
      req[p] = 1'b1;
      step();
      req[p] = 1'b0;
      wait_done(p, 1, ok);
      step();
      n_cmp++;
      if (!ok || gnt_port.size() != 1 || beats[p] != l + 1) begin
        n_bad++;
        $display("FAIL random[%0d]_burst: done=%0b grants=%0d beats=%0d, want 1/1/%0d",
                 it, ok, gnt_port.size(), beats[p], l + 1);
      end else if (gnt_port[0] != p) begin
        n_bad++;
        $display("FAIL random[%0d]_owner: port %0d, want %0d",
                 it, gnt_port[0], p);
      end
      if (w) begin
        for (int i = 0; i <= l; i++)
          refm[8'(a + i)] = (p == 0) ? wq0[i] : wq1[i];
      end else begin
        for (int i = 0; i <= l; i++) begin
          logic [7:0] got;
          got = (p == 0) ? ((i < rq0.size()) ? rq0[i] : 8'hxx)
                         : ((i < rq1.size()) ? rq1[i] : 8'hxx);
          n_cmp++;
          if (got !== refm[8'(a + i)]) begin
            n_bad++;
            $display("FAIL random[%0d]_rdata[%0d]: %h, want %h",
                     it, i, got, refm[8'(a + i)]);
          end
        end
      end
      tot += l + 1;
    end
    n_cmp++;
    if (mem_diffs() != 0) begin
      n_bad++;
      $display("FAIL random_mem: %0d bytes differ, want 0", mem_diffs());
    end
  endtask

  initial begin
    reset_n = 1'b0;
    req = 2'b00;
    we = 2'b00;
    p0_addr = '0; p1_addr = '0;
    p0_len = '0; p1_len = '0;
    p0_wdata = '0; p1_wdata = '0;
    pl_addr = '0; pl_data = '0;
    for (int i = 0; i < 256; i++) refm[i] = 8'(i) ^ 8'h5A;
    init_en = 1'b1;
    @(negedge clock);
    #1;
    init_en = 1'b0;
    clear_stats();

    test_reset();
    test_single_read();
    test_write_wrap();
    test_contention();
    test_drop_mid_burst();
    test_reset_mid_burst();
    test_back_to_back();
    test_random_bursts();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter and burst sequencer in front of the 256×8 `data_memory`. It shares that single memory between two requesters and sequences one access per cycle against it:
- Port 0: core load/store unit.
- Port 1: loader/DMA.

Arbitration is round-robin; a grant lasts for a burst of 1–8 beats at incrementing addresses. It sits between the requesters and the memory's `read`, `write`, `address` and `dataIn`/`dataOut` pins.

## Interface
- `NUM_REQ`, 2: number of requesters (fixed at 2; not generalised).
- `MAX_BEATS`, 8: maximum beats per burst; the `len` field is 3 bits.
- `clock`  in  1  single clock; all state updates on posedge.
- `reset_n`  in  1  reset, synchronous, active-low.
- `req`  in  [1:0]  per-port request level.
- `we`  in  [1:0]  per-port: 1 = write burst, 0 = read burst.
- `p0_addr`, `p1_addr`  in  8  burst base address.
- `p0_len`, `p1_len`  in  3  beats minus one.
- `p0_wdata`, `p1_wdata`  in  8  write data for the current beat.
- `gnt`  out  [1:0]  one-hot; high for every cycle of the owning burst.
- `beat`  out  [1:0]  high during each access cycle of the owner's burst.
- `rdata`  out  8  registered read data.
- `rdata_valid`  out  [1:0]  one-cycle pulse per read beat, to the owner.
- `done`  out  [1:0]  one-cycle pulse when the owner's burst completes.
- `mem_read`  out  1  to memory `read`.
- `mem_write`  out  1  to memory `write`.
- `mem_address`  out  8  to memory `address`.
- `mem_data_in`  out  8  to memory `dataIn`.
- `mem_data_out`  in  8  from memory `dataOut`.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- **IDLE**
  - No request: stay in IDLE.
  - Any `req` high: select a winner.
    - Only one port requests: that port wins.
    - Both request: the port that is not `last_owner` wins.
  - On winning: latch `we`, `addr` and `len` into `cur_*`, set `gnt[w]`, clear the beat counter, go to ACCESS.
- **ACCESS** (one cycle per beat)
  - `mem_address = cur_addr + beat_cnt`, modulo 256 (0xFF wraps to 0x00).
  - Read burst: `mem_read = 1`.
  - Write burst: `mem_write = 1`, and `mem_data_in` is a combinational mux of the owner's `wdata`.
  - `beat[owner] = 1`. The requester must present the next write word in the cycle after each `beat`.
  - Read beat: `mem_data_out` is registered into `rdata` at the closing posedge, and `rdata_valid[owner]` pulses in the following cycle.
  - `beat_cnt == cur_len`: go to DONE. Otherwise increment `beat_cnt`.
- **DONE** (one cycle)
  - `done[owner] = 1`; `gnt` stays high.
  - Update `last_owner`, then go to IDLE.
- `req`, `addr`, `len` and `we` are sampled only in IDLE.
  - Dropping `req` mid-burst has no effect; the burst completes.
  - Holding `req` after `done` starts a new arbitration in IDLE, which is how a requester issues a new burst.
- Outside ACCESS:
  - `mem_read = mem_write = 0`.
  - `mem_address` holds its last value.
  - `mem_data_in = 0`.
- **Reset values:** state IDLE; `gnt`, `beat`, `rdata_valid`, `done` = 0; `rdata` = 0; `mem_*` strobes = 0; `mem_address` = 0; `last_owner` = 1, so port 0 wins the first contention.
- **Reset mid-burst:** the burst aborts at the reset edge. No `done` is issued, and no memory strobe is asserted in the cycle after the reset edge.

## Timing
- **Request to first access:** `req` sampled high at posedge T0 → `gnt` and the first ACCESS cycle occupy T0→T1. Latency is 1 cycle.
- **Writes:** the memory commits on the negedge inside each ACCESS cycle. The address and data are stable from the preceding posedge, so no hold hazard exists.
- **Reads:** data for beat k is valid on `rdata` in ACCESS cycle k+1, or in DONE for the last beat.
- **Burst length:** `len + 1` ACCESS cycles plus 1 DONE cycle plus 1 IDLE cycle. The minimum turnaround between grants is `len + 3` cycles.
- **Fairness:** under continuous contention, grants alternate strictly 0, 1, 0, 1.

## Structure
- Package `mem_arb_pkg` holds:
  - the state enum `arb_state_t` (IDLE, ACCESS, DONE);
  - `ADDR_W = 8`, `DATA_W = 8`, `LEN_W = 3`.
- One sub-module, `rr_pick2`:
  - combinational two-way round-robin selector;
  - inputs `req[1:0]`, `last_owner`; outputs `winner`, `valid`.
- The top level holds the FSM, the latched command registers, the beat counter and the read-data register.

## Test plan
- **Single read, port 0:** memory preloaded with `mem[0x10] = 0xA5`; port 0 requests a read at 0x10, len 0. Required: `gnt[0]` at T1; `mem_read` for one cycle; `rdata = 0xA5` with `rdata_valid[0]` in DONE; `done[0]` pulses.
- **Write burst with wrap, port 1:** port 1 writes at base 0xFE, len 3, with data 0x11, 0x22, 0x33, 0x44. Required: memory addresses 0xFE, 0xFF, 0x00, 0x01 receive 0x11, 0x22, 0x33, 0x44 respectively; `beat[1]` high for exactly 4 cycles.
- **Simultaneous requests after reset:** both ports hold `req`, each with len 1. Required: grant order 0, 1, 0, with each burst lasting 4 cycles.
- **Request dropped mid-burst:** port 0 requests a read burst of len 7 and drops `req` after beat 2. Required: all 8 beats still execute; `done[0]` pulses once.
- **Reset mid-burst:** `reset_n` low during beat 3 of a write burst. Required:
  - In the cycle after the reset edge, `mem_write = 0` and all outputs equal their reset values.
  - No `done` is issued.
  - Memory contents from beat 3 onward are unchanged.
- **Back-to-back by one port:** port 1 holds `req` continuously while port 0 is idle. Required: grants repeat to port 1 with exactly one IDLE cycle between each `done` and the next grant.
